// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream
//   1:2 valid/ready stream demultiplexer. One input stream is steered to
//   output 0 or output 1. The route is picked from sel on the first beat of
//   a packet and then held until the beat flagged last is accepted.
//   Each output has one register stage, so latency is one cycle, and full
//   throughput is kept because a stage can drain and refill on the same edge.
//
// Ports
//   clk, rst_n                    clock (rising edge) and async active-low reset
//   in_data/in_valid/in_last      input beat
//   in_ready                      input beat accepted this cycle (combinational)
//   sel                           route select, sampled only while idle
//   out0_data/valid/last, out0_ready   output 0 stream (registered)
//   out1_data/valid/last, out1_ready   output 1 stream (registered)
//   busy                          1 while a multi-beat packet is in progress
//   route                         current target output
module demux_1to2_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    output logic             out0_last,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,
    output logic             busy,
    output logic             route
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             route_r;
    logic             route_nxt_s;
    logic             target_s;
    logic             accept_s;
    logic             load0_s;
    logic             load1_s;

    logic [WIDTH-1:0] out0_data_r;
    logic             out0_valid_r;
    logic             out0_last_r;
    logic [WIDTH-1:0] out1_data_r;
    logic             out1_valid_r;
    logic             out1_last_r;

    // Target selection and input handshake; only the target's stage gates in_ready.
    always_comb begin
        target_s = route_r;
        if (state_r == ST_IDLE) begin
            target_s = sel;
        end else begin
            target_s = route_r;
        end
        in_ready = 1'b0;
        if (target_s) begin
            in_ready = !out1_valid_r || out1_ready;
        end else begin
            in_ready = !out0_valid_r || out0_ready;
        end
        accept_s = in_valid && in_ready;
        load0_s  = accept_s && !target_s;
        load1_s  = accept_s && target_s;
    end

    // Next-state logic: lock on a non-last first beat, unlock when last is accepted.
    always_comb begin
        state_nxt_s = state_r;
        route_nxt_s = route_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !in_last) begin
                    state_nxt_s = ST_LOCKED;
                    route_nxt_s = sel;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && in_last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                route_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state and locked route register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            route_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            route_r <= route_nxt_s;
        end
    end

    // Output 0 stage: load on accept, clear valid once consumed and not refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_data_r  <= {WIDTH{1'b0}};
            out0_last_r  <= 1'b0;
            out0_valid_r <= 1'b0;
        end else if (load0_s) begin
            out0_data_r  <= in_data;
            out0_last_r  <= in_last;
            out0_valid_r <= 1'b1;
        end else if (out0_ready) begin
            out0_valid_r <= 1'b0;
        end
    end

    // Output 1 stage: same behaviour as output 0, drains independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_data_r  <= {WIDTH{1'b0}};
            out1_last_r  <= 1'b0;
            out1_valid_r <= 1'b0;
        end else if (load1_s) begin
            out1_data_r  <= in_data;
            out1_last_r  <= in_last;
            out1_valid_r <= 1'b1;
        end else if (out1_ready) begin
            out1_valid_r <= 1'b0;
        end
    end

    assign out0_data  = out0_data_r;
    assign out0_valid = out0_valid_r;
    assign out0_last  = out0_last_r;
    assign out1_data  = out1_data_r;
    assign out1_valid = out1_valid_r;
    assign out1_last  = out1_last_r;
    assign busy       = (state_r == ST_LOCKED);
    assign route      = target_s;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Testbench for demux_1to2_stream: directed packets, per-output expectation
// queues filled at input acceptance, and a monitor that pops and compares on
// every consumed output beat.
module tb_demux_1to2_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       sel;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_last;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_last;
    logic       out1_ready;
    logic       busy;
    logic       route;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         cyc;
        logic       strict;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic model_idle  = 1'b1;
    logic model_route = 1'b0;

    demux_1to2_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .sel(sel),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last), .out1_ready(out1_ready),
        .busy(busy), .route(route)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Monitor: compare each consumed beat against the head of its queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out0_valid === 1'b1 && out0_ready === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL out0_unexpected actual=%h/%b expected=none", out0_data, out0_last);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    if (out0_data !== e.d || out0_last !== e.l || (e.strict && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL out0_beat actual=%h/%b@%0d expected=%h/%b@%0d",
                                 out0_data, out0_last, cyc, e.d, e.l, e.cyc);
                    end
                end
            end
            if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL out1_unexpected actual=%h/%b expected=none", out1_data, out1_last);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    if (out1_data !== e.d || out1_last !== e.l || (e.strict && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL out1_beat actual=%h/%b@%0d expected=%h/%b@%0d",
                                 out1_data, out1_last, cyc, e.d, e.l, e.cyc);
                    end
                end
            end
        end
    end

    // Present one beat, wait (bounded) for acceptance, record expectation, update model.
    task automatic send(input logic [7:0] d, input logic l, input logic s);
        logic tgt;
        bit   ok;
        exp_t e;
        in_data  = d;
        in_last  = l;
        sel      = s;
        in_valid = 1'b1;
        tgt      = model_idle ? s : model_route;
        ok       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accept data=%h", d);
            in_valid = 1'b0;
            return;
        end
        e.d      = d;
        e.l      = l;
        e.cyc    = cyc + 1;
        e.strict = tgt ? out1_ready : out0_ready;
        if (tgt) q1.push_back(e);
        else     q0.push_back(e);
        @(posedge clk);
        #1;
        if (model_idle && !l) begin
            model_idle  = 1'b0;
            model_route = s;
        end else if (!model_idle && l) begin
            model_idle = 1'b1;
        end
        check1("busy", busy, !model_idle);
        if (!model_idle) check1("route_locked", route, model_route);
        in_valid = 1'b0;
    endtask

    initial begin
        int c0;
        rst_n      = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        sel        = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // 1: asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check1("rst_out0_valid", out0_valid, 1'b0);
        check1("rst_out1_valid", out1_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_out0_last", out0_last, 1'b0);
        checks++;
        if (out0_data !== 8'h00 || out1_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_data actual=%h/%h expected=00/00", out0_data, out1_data);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 2: 4-beat packet to out0
        send(8'h11, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h13, 1'b0, 1'b0);
        send(8'h14, 1'b1, 1'b0);
        @(posedge clk); #1;

        // 3: sel toggles mid-packet; all beats stay on out1
        send(8'h21, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b0);
        send(8'h23, 1'b0, 1'b1);
        send(8'h24, 1'b1, 1'b0);
        @(posedge clk); #1;

        // 4: out1 stalled with one beat; out0 still usable
        out1_ready = 1'b0;
        send(8'hB1, 1'b1, 1'b1);
        sel = 1'b1; #1;
        check1("inready_sel1_stalled", in_ready, 1'b0);
        sel = 1'b0; #1;
        check1("inready_sel0_free", in_ready, 1'b1);
        send(8'hA5, 1'b1, 1'b0);
        check1("out1_hold_valid", out1_valid, 1'b1);
        checks++;
        if (out1_data !== 8'hB1) begin
            errors++;
            $display("FAIL out1_hold_data actual=%h expected=b1", out1_data);
        end
        out1_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;

        // 5: back-to-back single-beat packets, no bubbles
        c0 = cyc;
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b1);
        send(8'h03, 1'b1, 1'b0);
        checks++;
        if (cyc - c0 != 3) begin
            errors++;
            $display("FAIL b2b_cycles actual=%0d expected=3", cyc - c0);
        end
        @(posedge clk); #1;

        // 6: reset in the middle of a packet
        send(8'h31, 1'b0, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        model_idle  = 1'b1;
        model_route = 1'b0;
        #1;
        check1("midrst_out0_valid", out0_valid, 1'b0);
        check1("midrst_out1_valid", out1_valid, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sel = 1'b1; #1;
        check1("route_idle_sel", route, 1'b1);
        send(8'h41, 1'b0, 1'b1);
        send(8'h42, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
